// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the logic_gate_pipe datapath.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 16;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Input/output handshake bundle of logic_gate_pipe; slave is the pipe side.
interface logic_gate_pipe_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
);
    import logic_gate_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [OP_W-1:0]         in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_zero;
    logic                    out_ones;
    logic                    out_parity;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_ones, out_parity
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_ones, out_parity
    );

endinterface

// File: rtl/logic_gate_pipe_stage.sv
// One valid/ready register slice: loads when empty or when its content leaves.
module pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready_c,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        in_ready_c = !valid_q || out_ready;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_ready_c) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage N-input bitwise logic unit with status flags and a transfer counter.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_gate_pipe_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned S2_W = WIDTH + 3;

    logic [WIDTH-1:0] and_r, or_r, xor_r, op0, res_c;
    logic             s1_ready_c, s1_valid, s2_ready_c, s2_valid;
    logic [WIDTH-1:0] s1_data;
    logic [S2_W-1:0]  s2_in, s2_data;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reduce all operands, then pick the requested function.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            and_r = and_r & bus.in_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | bus.in_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ bus.in_data[k*WIDTH +: WIDTH];
        end
        op0 = bus.in_data[WIDTH-1:0];
        case (op_e'(bus.in_op))
            OP_AND:  res_c = and_r;
            OP_OR:   res_c = or_r;
            OP_XOR:  res_c = xor_r;
            OP_NAND: res_c = ~and_r;
            OP_NOR:  res_c = ~or_r;
            OP_XNOR: res_c = ~xor_r;
            OP_NOT:  res_c = ~op0;
            default: res_c = op0;
        endcase
    end

    pipe_stage #(.DW(WIDTH)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_ready_c (s1_ready_c),
        .in_data    (res_c),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready_c),
        .out_data   (s1_data)
    );

    // Flags ride alongside the result as {parity, ones, zero, data}.
    assign s2_in = {^s1_data, &s1_data, ~|s1_data, s1_data};

    pipe_stage #(.DW(S2_W)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready_c),
        .in_data    (s2_in),
        .out_valid  (s2_valid),
        .out_ready  (bus.out_ready),
        .out_data   (s2_data)
    );

    assign bus.in_ready   = s1_ready_c;
    assign bus.out_valid  = s2_valid;
    assign bus.out_data   = s2_data[WIDTH-1:0];
    assign bus.out_zero   = s2_data[WIDTH];
    assign bus.out_ones   = s2_data[WIDTH+1];
    assign bus.out_parity = s2_data[WIDTH+2];

    // Clear has priority over a coincident transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)                         cnt_d = '0;
        else if (s2_valid && bus.out_ready)  cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: fixed vectors, backpressure, random scoreboard, counter and reset.
module tb_logic_gate_pipe;
    import logic_gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_clr2, cnt_clr4;
    logic [15:0] xfer_cnt2, xfer_cnt4;

    always #5 clk = ~clk;

    logic_gate_pipe_if #(.WIDTH(8), .NUM_IN(2)) bus2 ();
    logic_gate_pipe_if #(.WIDTH(8), .NUM_IN(4)) bus4 ();

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clr(cnt_clr2), .xfer_cnt(xfer_cnt2)
    );

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .cnt_clr(cnt_clr4), .xfer_cnt(xfer_cnt4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  exp;
        logic        zero;
        logic        ones;
        logic        par;
    } vec_t;

    vec_t tv2[12];
    vec_t tv4[5];

    int checks   = 0;
    int failures = 0;

    // Scoreboard state
    logic [7:0]  exp_q[$];
    int          sent = 0, recv = 0, target = 0, valid_pct = 100;
    bit          offer_v = 1'b0;
    logic [15:0] offer_d;
    logic [2:0]  offer_op;
    bit          stall_prev = 1'b0;
    logic [7:0]  prev_data;
    logic [2:0]  prev_flags;
    bit          force_clr = 1'b0, clr_on_out = 1'b0, clr_xfer_seen = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-bit count of ones across operands decides each function.
    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [31:0] d, input int n);
        logic [7:0] r;
        int c;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c = 0;
            for (int k = 0; k < n; k++) c += int'(d[k*8+b]);
            case (op)
                3'd0:    r[b] = (c == n);
                3'd1:    r[b] = (c > 0);
                3'd2:    r[b] = (c % 2 == 1);
                3'd3:    r[b] = (c != n);
                3'd4:    r[b] = (c == 0);
                3'd5:    r[b] = (c % 2 == 0);
                3'd6:    r[b] = d[b];
                default: r[b] = !d[b];
            endcase
        end
        return r;
    endfunction

    task automatic run_vec(input bit four, input vec_t v, input string nm);
        @(negedge clk);
        if (four) begin
            bus4.in_valid = 1'b1; bus4.in_data = v.data; bus4.in_op = v.op; bus4.out_ready = 1'b1;
        end else begin
            bus2.in_valid = 1'b1; bus2.in_data = v.data[15:0]; bus2.in_op = v.op; bus2.out_ready = 1'b1;
        end
        #1;
        check({nm, "_in_ready"}, 32'(four ? bus4.in_ready : bus2.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0; bus4.in_data = 32'hDEADBEEF; bus4.in_op = 3'd7;
        bus2.in_valid = 1'b0; bus2.in_data = 16'hBEEF;     bus2.in_op = 3'd7;
        #1;
        check({nm, "_lat1"}, 32'(four ? bus4.out_valid : bus2.out_valid), 32'd0);
        @(negedge clk);
        #1;
        if (four) begin
            check({nm, "_valid"}, 32'(bus4.out_valid), 32'd1);
            check({nm, "_data"},  32'(bus4.out_data), 32'(v.exp));
            check({nm, "_flags"}, 32'({bus4.out_zero, bus4.out_ones, bus4.out_parity}),
                  32'({v.zero, v.ones, v.par}));
        end else begin
            check({nm, "_valid"}, 32'(bus2.out_valid), 32'd1);
            check({nm, "_data"},  32'(bus2.out_data), 32'(v.exp));
            check({nm, "_flags"}, 32'({bus2.out_zero, bus2.out_ones, bus2.out_parity}),
                  32'({v.zero, v.ones, v.par}));
        end
    endtask

    // One cycle of randomised producer/consumer traffic on dut, checked against the model.
    task automatic sb_cycle(input bit ordy);
        logic [7:0] e;
        @(negedge clk);
        if (!offer_v && sent < target && int'($urandom_range(99)) < valid_pct) begin
            offer_v  = 1'b1;
            offer_d  = 16'($urandom);
            offer_op = 3'($urandom_range(7));
        end
        bus2.in_valid  = offer_v;
        bus2.in_data   = offer_v ? offer_d : 16'($urandom);
        bus2.in_op     = offer_v ? offer_op : 3'($urandom_range(7));
        bus2.out_ready = ordy;
        cnt_clr2       = force_clr || (clr_on_out && bus2.out_valid && ordy);
        #1;
        if (stall_prev) begin
            check("hold_valid", 32'(bus2.out_valid), 32'd1);
            check("hold_data",  32'(bus2.out_data), 32'(prev_data));
            check("hold_flags", 32'({bus2.out_zero, bus2.out_ones, bus2.out_parity}), 32'(prev_flags));
        end
        if (bus2.out_valid && ordy) begin
            if (cnt_clr2) clr_xfer_seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_spurious: got %0h expected no output", bus2.out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(bus2.out_data), 32'(e));
                check("sb_flags", 32'({bus2.out_zero, bus2.out_ones, bus2.out_parity}),
                      32'({e == 8'h00, e == 8'hFF, ^e}));
            end
            recv++;
        end
        stall_prev = bus2.out_valid && !ordy;
        prev_data  = bus2.out_data;
        prev_flags = {bus2.out_zero, bus2.out_ones, bus2.out_parity};
        if (offer_v && bus2.in_ready) begin
            exp_q.push_back(ref_result(offer_op, 32'(offer_d), 2));
            sent++;
            offer_v = 1'b0;
        end
    endtask

    initial begin
        int base;
        tv2[0]  = '{3'd0, 32'h0000F03C, 8'h30, 1'b0, 1'b0, 1'b0};
        tv2[1]  = '{3'd1, 32'h0000F03C, 8'hFC, 1'b0, 1'b0, 1'b0};
        tv2[2]  = '{3'd2, 32'h0000F03C, 8'hCC, 1'b0, 1'b0, 1'b0};
        tv2[3]  = '{3'd3, 32'h0000F03C, 8'hCF, 1'b0, 1'b0, 1'b0};
        tv2[4]  = '{3'd4, 32'h0000F03C, 8'h03, 1'b0, 1'b0, 1'b0};
        tv2[5]  = '{3'd5, 32'h0000F03C, 8'h33, 1'b0, 1'b0, 1'b0};
        tv2[6]  = '{3'd6, 32'h0000F03C, 8'h3C, 1'b0, 1'b0, 1'b0};
        tv2[7]  = '{3'd7, 32'h0000F03C, 8'hC3, 1'b0, 1'b0, 1'b0};
        tv2[8]  = '{3'd0, 32'h00000100, 8'h00, 1'b1, 1'b0, 1'b0};
        tv2[9]  = '{3'd1, 32'h00000100, 8'h01, 1'b0, 1'b0, 1'b1};
        tv2[10] = '{3'd3, 32'h00000100, 8'hFF, 1'b0, 1'b1, 1'b0};
        tv2[11] = '{3'd4, 32'h00000100, 8'hFE, 1'b0, 1'b0, 1'b1};
        tv4[0]  = '{3'd5, 32'h00FF5AA5, 8'hFF, 1'b0, 1'b1, 1'b0};
        tv4[1]  = '{3'd4, 32'hFFFFFFFF, 8'h00, 1'b1, 1'b0, 1'b0};
        tv4[2]  = '{3'd0, 32'h00FF5AA5, 8'h00, 1'b1, 1'b0, 1'b0};
        tv4[3]  = '{3'd1, 32'h00FF5AA5, 8'hFF, 1'b0, 1'b1, 1'b0};
        tv4[4]  = '{3'd2, 32'h01020408, 8'h0F, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        cnt_clr2 = 1'b0; cnt_clr4 = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_op = '0; bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_op = '0; bus4.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus2.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus2.in_ready), 32'd1);
        check("rst_out_data",  32'(bus2.out_data), 32'd0);
        check("rst_flags", 32'({bus2.out_zero, bus2.out_ones, bus2.out_parity}), 32'd0);
        check("rst_xfer_cnt",  32'(xfer_cnt2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(1'b0, tv2[i], $sformatf("tv2_%0d", i));
        for (int i = 0; i < 5; i++)  run_vec(1'b1, tv4[i], $sformatf("tv4_%0d", i));

        // Five back-to-back transactions against a stalled consumer
        base = sent; target = sent + 5; valid_pct = 100;
        force_clr = 1'b1; sb_cycle(1'b0); force_clr = 1'b0;
        repeat (7) sb_cycle(1'b0);
        check("bp_accepted", 32'(sent - base), 32'd2);
        check("bp_in_ready", 32'(bus2.in_ready), 32'd0);
        check("bp_cnt_stall", 32'(xfer_cnt2), 32'd0);
        for (int i = 0; i < 50 && recv < target; i++) sb_cycle(1'b1);
        check("bp_drained", 32'(recv), 32'(target));
        sb_cycle(1'b1);
        check("bp_xfer_cnt", 32'(xfer_cnt2), 32'd5);

        // Random valid/ready traffic
        target = sent + 1000; valid_pct = 70;
        for (int i = 0; i < 20000 && recv < target; i++) sb_cycle(int'($urandom_range(99)) < 60);
        check("rand_done", 32'(recv), 32'(target));
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // Counter saturation and clear priority
        force_clr = 1'b1; sb_cycle(1'b1); force_clr = 1'b0;
        target = sent + 65534; valid_pct = 100;
        for (int i = 0; i < 70000 && recv < target; i++) sb_cycle(1'b1);
        sb_cycle(1'b1);
        check("cnt_fffe", 32'(xfer_cnt2), 32'h0000FFFE);
        target = sent + 3;
        for (int i = 0; i < 50 && recv < target; i++) sb_cycle(1'b1);
        sb_cycle(1'b1);
        check("cnt_sat", 32'(xfer_cnt2), 32'h0000FFFF);
        target = sent + 1; clr_on_out = 1'b1;
        for (int i = 0; i < 50 && recv < target; i++) sb_cycle(1'b1);
        clr_on_out = 1'b0;
        check("clr_coincident", 32'(clr_xfer_seen), 32'd1);
        sb_cycle(1'b1);
        check("cnt_clr_wins", 32'(xfer_cnt2), 32'd0);

        // Reset with two transactions in flight
        target = sent + 2;
        repeat (4) sb_cycle(1'b0);
        check("rst_preload", 32'(sent), 32'(target));
        check("rst_full_valid", 32'(bus2.out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus2.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus2.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus2.in_ready), 32'd1);
        check("midrst_out_data",  32'(bus2.out_data), 32'd0);
        check("midrst_xfer_cnt",  32'(xfer_cnt2), 32'd0);
        exp_q.delete();
        offer_v = 1'b0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) sb_cycle(1'b1);
        check("postrst_in_ready", 32'(bus2.in_ready), 32'd1);
        check("postrst_no_stale", 32'(bus2.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, is the bit width of each operand and of the result; legal range 1..32.
REQ-002 Parameter NUM_IN, default 2, is the number of operands combined per transaction; legal range 2..8.
REQ-003 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit, marks that the input transaction is valid.
REQ-006 Port in_ready, output, 1 bit, indicates the block accepts an input transaction this cycle.
REQ-007 Port in_data, input, NUM_IN*WIDTH bits, carries the operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port in_op, input, 3 bits, selects the operation and is sampled together with in_data.
REQ-009 Port out_valid, output, 1 bit, marks that the output transaction is valid.
REQ-010 Port out_ready, input, 1 bit, indicates the consumer accepts the output transaction.
REQ-011 Port out_data, output, WIDTH bits, carries the result.
REQ-012 Port out_zero, output, 1 bit, is set when out_data is all zeros.
REQ-013 Port out_ones, output, 1 bit, is set when out_data is all ones.
REQ-014 Port out_parity, output, 1 bit, is the XOR reduction of out_data.
REQ-015 Port cnt_clr, input, 1 bit, synchronously clears the transfer counter.
REQ-016 Port xfer_cnt, output, 16 bits, counts completed output transfers.

Function
REQ-017 The in_op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS (operand 0), 7 NOT (inverted operand 0).
REQ-018 Ops 0-5 SHALL combine all NUM_IN operands bitwise; NAND/NOR/XNOR are the inversions of the NUM_IN-input AND/OR/XOR.
REQ-019 The datapath SHALL be a two-stage pipeline: stage 1 registers the result, stage 2 registers the result plus out_zero, out_ones and out_parity.
REQ-020 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-021 Latency from input transfer to out_valid SHALL be exactly 2 cycles when there is no backpressure.
REQ-022 A stage SHALL load when it is empty or its contents advance in the same cycle; in_ready = !s1_valid || s1_advances.
REQ-023 Throughput SHALL be one transaction per cycle while out_ready is held high.
REQ-024 While out_valid && !out_ready, out_data, the flags and out_valid SHALL hold stable.
REQ-025 Under sustained backpressure, the block SHALL hold at most 2 transactions, with none lost or duplicated, and in_ready SHALL be low once both stages are full.
REQ-026 The block SHALL not depend on in_valid falling after a transfer; back-to-back transfers are legal.
REQ-027 xfer_cnt SHALL increment by 1 on each output transfer and saturate at 16'hFFFF.
REQ-028 If cnt_clr and an output transfer occur in the same cycle, xfer_cnt SHALL become 0, and clear wins.
REQ-029 Values of in_data and in_op when no input transfer occurs SHALL have no effect.

Reset
REQ-030 While rst_n is low, out_valid, out_data, out_zero, out_ones, out_parity, xfer_cnt and all stage valids SHALL be 0, and in_ready SHALL be 1.
REQ-031 A reset asserted mid-transaction SHALL discard all in-flight transactions; reset deassertion is synchronised by the integrator.

Structure
REQ-032 The op encoding SHALL be an enum typedef in package logic_gate_pkg, together with the counter width constant.
REQ-033 Each pipeline stage SHALL be an instance of one sub-module, pipe_stage, a parametrised valid/ready register.

Verification
REQ-034 WIDTH=8, NUM_IN=2, op AND, in_data {8'hF0, 8'h3C}, out_ready=1 -> out_data 8'h30, zero 0, ones 0, parity 0, 2 cycles after input.
REQ-035 NUM_IN=4, op XNOR, operands A5,5A,FF,00 -> out_data 8'hFF and out_ones=1; op NOR on all-0xFF operands -> 8'h00 and out_zero=1.
REQ-036 Stream 5 transactions with out_ready=0 -> in_ready falls after 2 transfers; releasing out_ready yields the 5 results in order, and xfer_cnt=5.
REQ-037 Random in_valid/out_ready toggling over 1000 transactions -> scoreboard matches with no loss or duplication, and outputs stay stable while stalled.
REQ-038 Preload xfer_cnt=16'hFFFE, do 3 transfers -> FFFF held; cnt_clr coincident with a transfer -> xfer_cnt 0.
REQ-039 Assert rst_n low with 2 transactions in flight -> out_valid 0 immediately, no stale result after release, and in_ready=1.
